// File: rtl/mc_pkg.sv
// Shared definitions for the full-search motion estimator.
// Holds the controller state encoding, geometry helpers (window edge,
// candidate count, SAD accumulator width) and the fixed indices of
// the dx/dy/residual beats in a result frame.
package mc_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEARCH = 2'd1,
        OUT    = 2'd2
    } state_t;

    localparam int BEAT_DX   = 0;
    localparam int BEAT_DY   = 1;
    localparam int BEAT_RES0 = 2;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int clog2(input longint v);
        int     r;
        longint p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Width that holds the worst-case SAD of a BxB block without overflow.
    function automatic int sad_width(input int pw, input int b);
        return clog2(longint'(b) * longint'(b) * ((longint'(1) << pw) - 1) + 1);
    endfunction

    function automatic int nc(input int r);
        return (2 * r + 1) * (2 * r + 1);
    endfunction

    function automatic int w(input int b, input int r);
        return b + 2 * r;
    endfunction

endpackage

// File: rtl/mc_sad_tree.sv
// Combinational block-difference unit.
// Ports:
//   cur_i  - NP current-block pixels, raster order
//   ref_i  - NP reference pixels of one candidate, raster order
//   sad_o  - sum of absolute differences, full precision
//   res_o  - NP signed residuals cur-ref (PW+1 bits)
// The absolute differences are summed in a balanced binary tree so the
// depth grows with log2(NP) and one candidate fits in a single cycle.
module mc_sad_tree
    import mc_pkg::*;
#(
    parameter int PW = 8,
    parameter int B  = 2
) (
    input  logic        [PW-1:0]              cur_i [B*B],
    input  logic        [PW-1:0]              ref_i [B*B],
    output logic        [sad_width(PW,B)-1:0] sad_o,
    output logic signed [PW:0]                res_o [B*B]
);

    localparam int NP = B * B;
    localparam int SW = sad_width(PW, B);
    localparam int LV = clog2(NP);

    logic [SW-1:0] node [LV+1][NP];

    // Level 0 holds |cur-ref|; each further level halves the node count.
    always_comb begin
        for (int l = 0; l <= LV; l++) begin
            for (int n = 0; n < NP; n++) begin
                node[l][n] = '0;
            end
        end
        for (int n = 0; n < NP; n++) begin
            res_o[n] = $signed({1'b0, cur_i[n]}) - $signed({1'b0, ref_i[n]});
            node[0][n] = (cur_i[n] >= ref_i[n]) ? SW'(cur_i[n] - ref_i[n])
                                                : SW'(ref_i[n] - cur_i[n]);
        end
        for (int l = 0; l < LV; l++) begin
            for (int n = 0; n < (NP >> (l + 1)); n++) begin
                node[l+1][n] = node[l][2*n] + node[l][2*n+1];
            end
        end
        sad_o = node[LV][0];
    end

endmodule

// File: rtl/mc_fullsearch.sv
// Full-search block-matching motion estimator.
// Ports:
//   CLK, RESET       - clock and synchronous active-high reset
//   in, in_valid     - serial pixels: BxB current block then WxW window
//   in_ready         - high while the block is loading
//   out, out_valid   - result beats: dx, dy, NP residuals, MAD
//   out_last         - marks the MAD beat, the last of each frame
// One candidate displacement is scored per cycle; the best (lowest SAD,
// earliest on ties) is kept with its residuals and streamed afterwards.
module mc_fullsearch
    import mc_pkg::*;
#(
    parameter int PW = 8,
    parameter int B  = 2,
    parameter int R  = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [PW-1:0]      in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [PW:0] out,
    output logic               out_valid,
    output logic               out_last
);

    localparam int NP    = B * B;
    localparam int WE    = w(B, R);
    localparam int SW    = sad_width(PW, B);
    localparam int SPAN  = 2 * R + 1;
    localparam int NLOAD = NP + WE * WE;
    localparam int LDW   = clog2(NLOAD);
    localparam int WAW   = clog2(WE * WE);
    localparam int NPW   = clog2(NP);
    localparam int CW    = clog2(SPAN);
    localparam int BTW   = clog2(NP + 3);

    localparam logic [LDW-1:0] LD_NP   = LDW'(NP);
    localparam logic [LDW-1:0] LD_LAST = LDW'(NLOAD - 1);
    localparam logic [CW-1:0]  C_LAST  = CW'(SPAN - 1);
    localparam logic [BTW-1:0] BT_DX   = BTW'(BEAT_DX);
    localparam logic [BTW-1:0] BT_DY   = BTW'(BEAT_DY);
    localparam logic [BTW-1:0] BT_RES0 = BTW'(BEAT_RES0);
    localparam logic [BTW-1:0] BT_LAST = BTW'(NP + BEAT_RES0);

    state_t                state_q, state_d;
    logic [LDW-1:0]        ldCnt_q, ldCnt_d;
    logic [CW-1:0]         cx_q, cx_d, cy_q, cy_d;
    logic [CW-1:0]         bestCx_q, bestCx_d, bestCy_q, bestCy_d;
    logic [SW-1:0]         bestSad_q, bestSad_d;
    logic [BTW-1:0]        beat_q, beat_d;
    logic signed [PW:0]    out_q, out_d;
    logic                  valid_q, valid_d, last_q, last_d;
    logic                  curWe, winWe, resWe;

    logic [PW-1:0]         curPix_q [NP];
    logic [PW-1:0]         winPix_q [WE*WE];
    logic signed [PW:0]    bestRes_q [NP];
    logic [PW-1:0]         refPix [NP];
    logic [SW-1:0]         candSad;
    logic signed [PW:0]    candRes [NP];
    logic                  better;
    logic [CW-1:0]         finCx;
    logic [BTW-1:0]        nextBeat;
    logic signed [PW:0]    beatVal;

    // Reference block of the current candidate: window offset (cy, cx).
    always_comb begin
        for (int i = 0; i < B; i++) begin
            for (int j = 0; j < B; j++) begin
                refPix[i*B+j] = winPix_q[WAW'((int'(cy_q) + i) * WE + int'(cx_q) + j)];
            end
        end
    end

    mc_sad_tree #(.PW(PW), .B(B)) u_tree (
        .cur_i (curPix_q),
        .ref_i (refPix),
        .sad_o (candSad),
        .res_o (candRes)
    );

    // The last candidate's comparison must already be reflected in the
    // dx beat issued on the same edge, hence the bypass through finCx.
    always_comb begin
        better   = (candSad < bestSad_q);
        finCx    = better ? cx_q : bestCx_q;
        nextBeat = beat_q + BTW'(1);
        if (nextBeat == BT_DY) begin
            beatVal = (PW+1)'(int'(bestCy_q) - R);
        end else if (nextBeat == BT_LAST) begin
            beatVal = (PW+1)'((bestSad_q + SW'(NP / 2)) >> NPW);
        end else begin
            beatVal = bestRes_q[NPW'(nextBeat - BT_RES0)];
        end
    end

    // Controller next state and output-beat sequencing.
    always_comb begin
        state_d   = state_q;
        ldCnt_d   = ldCnt_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        bestCx_d  = bestCx_q;
        bestCy_d  = bestCy_q;
        bestSad_d = bestSad_q;
        beat_d    = beat_q;
        out_d     = out_q;
        valid_d   = valid_q;
        last_d    = last_q;
        curWe     = 1'b0;
        winWe     = 1'b0;
        resWe     = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    curWe = (ldCnt_q < LD_NP);
                    winWe = !(ldCnt_q < LD_NP);
                    if (ldCnt_q == LD_LAST) begin
                        ldCnt_d   = '0;
                        cx_d      = '0;
                        cy_d      = '0;
                        bestCx_d  = '0;
                        bestCy_d  = '0;
                        bestSad_d = '1;
                        state_d   = SEARCH;
                    end else begin
                        ldCnt_d = ldCnt_q + LDW'(1);
                    end
                end
            end
            SEARCH: begin
                if (better) begin
                    bestSad_d = candSad;
                    bestCx_d  = cx_q;
                    bestCy_d  = cy_q;
                    resWe     = 1'b1;
                end
                if (cx_q == C_LAST) begin
                    cx_d = '0;
                    cy_d = cy_q + CW'(1);
                end else begin
                    cx_d = cx_q + CW'(1);
                end
                if (cx_q == C_LAST && cy_q == C_LAST) begin
                    state_d = OUT;
                    beat_d  = BT_DX;
                    out_d   = (PW+1)'(int'(finCx) - R);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            OUT: begin
                if (beat_q == BT_LAST) begin
                    state_d = LOAD;
                    out_d   = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else begin
                    beat_d = nextBeat;
                    out_d  = beatVal;
                    last_d = (nextBeat == BT_LAST);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Control registers; reset abandons any frame in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= LOAD;
            ldCnt_q   <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            bestCx_q  <= '0;
            bestCy_q  <= '0;
            bestSad_q <= '1;
            beat_q    <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ldCnt_q   <= ldCnt_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            bestCx_q  <= bestCx_d;
            bestCy_q  <= bestCy_d;
            bestSad_q <= bestSad_d;
            beat_q    <= beat_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    // Pixel and residual storage; always rewritten before use.
    always_ff @(posedge CLK) begin
        if (curWe) begin
            curPix_q[ldCnt_q[NPW-1:0]] <= in;
        end
        if (winWe) begin
            winPix_q[WAW'(ldCnt_q - LD_NP)] <= in;
        end
        if (resWe) begin
            for (int n = 0; n < NP; n++) begin
                bestRes_q[n] <= candRes[n];
            end
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out       = out_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule
